// File: rtl/texture_loader_pkg.sv
// Shared types and constants for the serial texture loader: FSM state enums, sync byte,
// address field widths and the bank one-hot helper.
package texture_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned BANK_W    = 3;
    localparam int unsigned HI_W      = 2;
    localparam int unsigned BRAM_W    = 8;
    localparam int unsigned BANK_LSB  = BRAM_W + HI_W;

    typedef enum logic [2:0] {
        PktHunt,
        PktAddrH,
        PktAddrL,
        PktLenH,
        PktLenL,
        PktData,
        PktCksum
    } pkt_state_e;

    typedef enum logic [2:0] {
        WIdle,
        WSetup,
        WStrobe,
        WHold,
        WInc
    } wr_state_e;

    function automatic logic [7:0] bank_onehot(input logic [BANK_W-1:0] bank);
        logic [7:0] oh;
        oh       = '0;
        oh[bank] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/serial_deser.sv
// Serial front end: synchronisers, dual-edge bit clock detector, bit counter and the
// sync-hunt shift register. Emits assembled bytes (MSB first) with a one-cycle valid.
module serial_deser
    import texture_loader_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_clk,
    input  logic       serial_data,
    input  logic       hunt_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       sync_found_o
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] sdat_q;
    logic                   sclk_last_q;
    logic [7:0]             shift_q;
    logic [2:0]             bit_cnt_q;
    logic                   byte_valid_q;
    logic                   sync_found_q;
    logic                   sample;
    logic [7:0]             shift_next;

    // Either edge of the synchronised bit clock samples the data from the same stage.
    assign sample     = sclk_q[SYNC_STAGES-1] ^ sclk_last_q;
    assign shift_next = {shift_q[6:0], sdat_q[SYNC_STAGES-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q       <= '0;
            sdat_q       <= '0;
            sclk_last_q  <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            sync_found_q <= 1'b0;
        end else begin
            sclk_q       <= {sclk_q[SYNC_STAGES-2:0], serial_clk};
            sdat_q       <= {sdat_q[SYNC_STAGES-2:0], serial_data};
            sclk_last_q  <= sclk_q[SYNC_STAGES-1];
            byte_valid_q <= 1'b0;
            sync_found_q <= 1'b0;
            if (sample) begin
                shift_q <= shift_next;
                if (hunt_i) begin
                    bit_cnt_q <= '0;
                    if (shift_next == SYNC_BYTE) begin
                        sync_found_q <= 1'b1;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign sync_found_o = sync_found_q;

endmodule

// File: rtl/texture_loader.sv
// Serial texture loader: parses A5-framed packets and writes bytes into 8 BRAM banks.
// Define LOADER_CHECKSUM_EN to expect and check a trailing XOR checksum byte.
module texture_loader
    import texture_loader_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 3,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_clk,
    input  logic              serial_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        wr_strobe,
    output logic              busy,
    output logic              done,
    output logic              err_cksum,
    output logic              err_overrun
);

`ifdef LOADER_CHECKSUM_EN
    localparam bit CksumEn = 1'b1;
`else
    localparam bit CksumEn = 1'b0;
`endif

    pkt_state_e        pkt_q;
    wr_state_e         wst_q;
    logic [15:0]       cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic [7:0]        strobe_q;
    logic [7:0]        scnt_q;
    logic              busy_q;
    logic              done_q;
    logic              done_pend_q;
    logic              err_ovr_q;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              sync_found;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        cksum_q;
    logic              err_ck_q;
`endif

    serial_deser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .clk          (clk),
        .reset        (reset),
        .serial_clk   (serial_clk),
        .serial_data  (serial_data),
        .hunt_i       (pkt_q == PktHunt),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .sync_found_o (sync_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q       <= PktHunt;
            wst_q       <= WIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            strobe_q    <= '0;
            scnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_pend_q <= 1'b0;
            err_ovr_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cksum_q     <= '0;
            err_ck_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;

            unique case (wst_q)
                WIdle: ;
                WSetup: begin
                    wst_q    <= WStrobe;
                    strobe_q <= bank_onehot(addr_q[BANK_LSB +: BANK_W]);
                    scnt_q   <= '0;
                end
                WStrobe: begin
                    if (scnt_q == 8'(STROBE_CYCLES - 1)) begin
                        strobe_q <= '0;
                        wst_q    <= WHold;
                    end else begin
                        scnt_q <= scnt_q + 8'd1;
                    end
                end
                WHold: wst_q <= WInc;
                WInc: begin
                    addr_q <= addr_q + 13'd1;
                    wst_q  <= WIdle;
                end
                default: wst_q <= WIdle;
            endcase

            if (pkt_q == PktHunt && sync_found) begin
                pkt_q  <= PktAddrH;
                busy_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                cksum_q <= '0;
`endif
            end else if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                if (pkt_q != PktCksum) begin
                    cksum_q <= cksum_q ^ rx_byte;
                end
`endif
                case (pkt_q)
                    PktAddrH: begin
                        addr_q[ADDR_W-1:BRAM_W] <= rx_byte[ADDR_W-BRAM_W-1:0];
                        pkt_q <= PktAddrL;
                    end
                    PktAddrL: begin
                        addr_q[BRAM_W-1:0] <= rx_byte;
                        pkt_q <= PktLenH;
                    end
                    PktLenH: begin
                        cnt_q[15:8] <= rx_byte;
                        pkt_q <= PktLenL;
                    end
                    PktLenL: begin
                        cnt_q[7:0] <= rx_byte;
                        if ({cnt_q[15:8], rx_byte} == 16'd0) begin
                            if (CksumEn) begin
                                pkt_q <= PktCksum;
                            end else begin
                                pkt_q       <= PktHunt;
                                done_pend_q <= 1'b1;
                            end
                        end else begin
                            pkt_q <= PktData;
                        end
                    end
                    PktData: begin
                        cnt_q <= cnt_q - 16'd1;
                        // A byte arriving mid-write is lost but still consumes its slot.
                        if (wst_q == WIdle) begin
                            data_q <= rx_byte;
                            wst_q  <= WSetup;
                        end else begin
                            err_ovr_q <= 1'b1;
                        end
                        if (cnt_q == 16'd1) begin
                            if (CksumEn) begin
                                pkt_q <= PktCksum;
                            end else begin
                                pkt_q       <= PktHunt;
                                done_pend_q <= 1'b1;
                            end
                        end
                    end
                    PktCksum: begin
`ifdef LOADER_CHECKSUM_EN
                        if (rx_byte != cksum_q) begin
                            err_ck_q <= 1'b1;
                        end
`endif
                        pkt_q       <= PktHunt;
                        done_pend_q <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // Completion waits for the last write to drain back to idle.
            if (done_pend_q && wst_q == WIdle) begin
                done_q      <= 1'b1;
                busy_q      <= 1'b0;
                done_pend_q <= 1'b0;
            end
        end
    end

    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign wr_strobe   = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_overrun = err_ovr_q;
`ifdef LOADER_CHECKSUM_EN
    assign err_cksum   = err_ck_q;
`else
    assign err_cksum   = 1'b0;
`endif

endmodule

// File: tb/tb_texture_loader.sv
// Directed bench for texture_loader: sends framed packets bit-serially and checks the
// captured bank writes, done/busy handshake, error flags and reset behaviour.
module tb_texture_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        serial_clk = 1'b0;
    logic        serial_data = 1'b0;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  wr_strobe;
    logic        busy;
    logic        done;
    logic        err_cksum;
    logic        err_overrun;

    texture_loader #(
        .SYNC_STAGES   (3),
        .STROBE_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_clk  (serial_clk),
        .serial_data (serial_data),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strobe   (wr_strobe),
        .busy        (busy),
        .done        (done),
        .err_cksum   (err_cksum),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: one entry per strobe burst.
    logic [12:0] w_addr[$];
    logic [7:0]  w_data[$];
    logic [7:0]  w_strb[$];
    int          w_len[$];
    int          done_cnt   = 0;
    int          onehot_bad = 0;
    int          bank_bad   = 0;

    initial begin
        logic [7:0] prev;
        int         run;
        prev = '0;
        run  = 0;
        forever begin
            @(negedge clk);
            if (wr_strobe != 8'h00) begin
                if ($countones(wr_strobe) != 1) onehot_bad++;
                if (prev == 8'h00) begin
                    w_addr.push_back(wr_addr);
                    w_data.push_back(wr_data);
                    w_strb.push_back(wr_strobe);
                    if (wr_strobe != (8'h01 << wr_addr[12:10])) bank_bad++;
                    run = 1;
                end else begin
                    run++;
                end
            end else if (prev != 8'h00) begin
                w_len.push_back(run);
            end
            if (done) done_cnt++;
            prev = wr_strobe;
        end
    end

    logic [7:0] tx[$];
    int         done_base;

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk);
            serial_data = b[i];
            repeat (4) @(posedge clk);
            serial_clk = ~serial_clk;
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic send_tx();
        send_byte(8'h00);
        foreach (tx[i]) send_byte(tx[i]);
    endtask

    task automatic start_test();
        @(posedge clk);
        w_addr.delete();
        w_data.delete();
        w_strb.delete();
        w_len.delete();
        done_base = done_cnt;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq({tag, "_done"}, 32'(seen), 32'd1);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check_eq({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
    endtask

    initial begin
        bit seen;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_addr", 32'(wr_addr), 32'h0);
        check_eq("rst_data", 32'(wr_data), 32'h0);
        check_eq("rst_strobe", 32'(wr_strobe), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_err_ck", 32'(err_cksum), 32'h0);
        check_eq("rst_err_ovr", 32'(err_overrun), 32'h0);
        reset = 1'b0;

        // Basic two-byte packet into bank 0.
        start_test();
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'h00);
        @(negedge clk);
        check_eq("t1_busy_mid", 32'(busy), 32'd1);
        tx = '{8'h10, 8'h00, 8'h02, 8'h11, 8'h22};
`ifdef LOADER_CHECKSUM_EN
        tx.push_back(8'h21);
`endif
        foreach (tx[i]) send_byte(tx[i]);
        wait_done("t1");
        check_eq("t1_nwr", 32'(w_addr.size()), 32'd2);
        check_eq("t1_addr0", 32'(w_addr[0]), 32'h010);
        check_eq("t1_data0", 32'(w_data[0]), 32'h11);
        check_eq("t1_strb0", 32'(w_strb[0]), 32'h01);
        check_eq("t1_len0", 32'(w_len[0]), 32'd2);
        check_eq("t1_addr1", 32'(w_addr[1]), 32'h011);
        check_eq("t1_data1", 32'(w_data[1]), 32'h22);
        check_eq("t1_len1", 32'(w_len[1]), 32'd2);
        check_eq("t1_err_ck", 32'(err_cksum), 32'd0);

        // Top bank.
        start_test();
        tx = '{8'hA5, 8'h1C, 8'h00, 8'h00, 8'h01, 8'h77};
`ifdef LOADER_CHECKSUM_EN
        tx.push_back(8'h6A);
`endif
        send_tx();
        wait_done("t2");
        check_eq("t2_strb", 32'(w_strb[0]), 32'h80);
        check_eq("t2_addr_lo", 32'(w_addr[0][7:0]), 32'h00);
        check_eq("t2_addr", 32'(w_addr[0]), 32'h1C00);
        check_eq("t2_data", 32'(w_data[0]), 32'h77);

        // Address wrap 0x1FFF -> 0x0000.
        start_test();
        tx = '{8'hA5, 8'h1F, 8'hFF, 8'h00, 8'h02, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
        tx.push_back(8'h95);
`endif
        send_tx();
        wait_done("t3");
        check_eq("t3_nwr", 32'(w_addr.size()), 32'd2);
        check_eq("t3_addr0", 32'(w_addr[0]), 32'h1FFF);
        check_eq("t3_strb0", 32'(w_strb[0]), 32'h80);
        check_eq("t3_addr1", 32'(w_addr[1]), 32'h0000);
        check_eq("t3_strb1", 32'(w_strb[1]), 32'h01);
        check_eq("t3_data1", 32'(w_data[1]), 32'h44);

        // Zero-length packet: header only.
        start_test();
        tx = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        tx.push_back(8'h01);
`endif
        send_tx();
        wait_done("t5");
        check_eq("t5_nwr", 32'(w_addr.size()), 32'd0);
        check_eq("t5_err_ck", 32'(err_cksum), 32'd0);

        // Reset in the middle of a strobe.
        start_test();
        tx = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h02, 8'h66};
        send_tx();
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (wr_strobe != 8'h00) seen = 1'b1;
        end
        check_eq("t6_strobe_seen", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t6_strobe_rst", 32'(wr_strobe), 32'h0);
        check_eq("t6_busy_rst", 32'(busy), 32'h0);
        check_eq("t6_addr_rst", 32'(wr_addr), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        start_test();
        tx = '{8'hA5, 8'h00, 8'h50, 8'h00, 8'h01, 8'h99};
`ifdef LOADER_CHECKSUM_EN
        tx.push_back(8'hC8);
`endif
        send_tx();
        wait_done("t6b");
        check_eq("t6b_nwr", 32'(w_addr.size()), 32'd1);
        check_eq("t6b_addr", 32'(w_addr[0]), 32'h050);
        check_eq("t6b_data", 32'(w_data[0]), 32'h99);
        check_eq("t6b_strb", 32'(w_strb[0]), 32'h01);

        check_eq("err_overrun_clear", 32'(err_overrun), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: data still lands, flag sets, done still pulses.
        start_test();
        tx = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h55, 8'h00};
        send_tx();
        wait_done("t4");
        check_eq("t4_err_ck", 32'(err_cksum), 32'd1);
        check_eq("t4_addr", 32'(w_addr[0]), 32'h020);
        check_eq("t4_data", 32'(w_data[0]), 32'h55);
`endif

        check_eq("strobe_onehot", 32'(onehot_bad), 32'd0);
        check_eq("strobe_bank", 32'(bank_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
